// File: rtl/ucsbece152a_counter_ctrl.sv
// Button front end and direction FSM for ucsbece152a_counter: synchronizes, debounces
// and edge-detects three buttons, then steers the counter's enable/dir with optional bounce.
module ucsbece152a_counter_ctrl #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic             btn_pause_i,
  input  logic             mode_bounce_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             enable_o,
  output logic             dir_o,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UP     = 2'd1;
  localparam logic [1:0] DOWN   = 2'd2;
  localparam logic [1:0] PAUSED = 2'd3;

  localparam logic [CW-1:0]    CNT_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [WIDTH-1:0] TURN_HIGH = WIDTH'((2 ** WIDTH) - 2);
  localparam logic [WIDTH-1:0] TURN_LOW  = WIDTH'(1);

  // Bit 0 = up, bit 1 = down, bit 2 = pause throughout the button path.
  logic [2:0]    btn_raw;
  logic [2:0]    sync_a;
  logic [2:0]    sync_b;
  logic [CW-1:0] cnt [3];
  logic [2:0]    level;
  logic [2:0]    level_prev;
  logic [2:0]    press;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       saved_dir;
  logic       saved_dir_next;

  assign btn_raw = {btn_pause_i, btn_down_i, btn_up_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a     <= '0;
      sync_b     <= '0;
      level_prev <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_a     <= btn_raw;
      sync_b     <= sync_a;
      level_prev <= level;
      for (int i = 0; i < 3; i++) begin
        if (!sync_b[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      level[i] = (cnt[i] == CNT_MAX);
    end
  end

  assign press = level & ~level_prev;

  // Button events take priority over the bounce reversal; pause beats down beats up.
  always_comb begin
    state_next     = state;
    saved_dir_next = saved_dir;
    if (press[2]) begin
      case (state)
        UP: begin
          state_next     = PAUSED;
          saved_dir_next = 1'b0;
        end
        DOWN: begin
          state_next     = PAUSED;
          saved_dir_next = 1'b1;
        end
        PAUSED:  state_next = saved_dir ? DOWN : UP;
        default: state_next = IDLE;
      endcase
    end else if (press[1]) begin
      state_next = DOWN;
    end else if (press[0]) begin
      state_next = UP;
    end else if (mode_bounce_i) begin
      if (state == UP && count_i == TURN_HIGH) begin
        state_next = DOWN;
      end else if (state == DOWN && count_i == TURN_LOW) begin
        state_next = UP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      saved_dir <= 1'b0;
    end else begin
      state     <= state_next;
      saved_dir <= saved_dir_next;
    end
  end

  assign state_o  = state;
  assign enable_o = (state == UP) || (state == DOWN);
  assign dir_o    = (state == DOWN) || ((state == PAUSED) && saved_dir);

endmodule

// File: tb/tb_ucsbece152a_counter_ctrl.sv
// Self-checking bench for ucsbece152a_counter_ctrl driving a behavioural 3-bit counter
// built into the bench, with table-driven button presses plus multi-cycle corner cases.
module tb_ucsbece152a_counter_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_pause;
  logic       mode_bounce;
  logic [2:0] count;
  logic       enable;
  logic       dir;
  logic [1:0] state;

  int total;
  int bad;

  typedef struct {
    logic       up;
    logic       down;
    logic       pause;
    int         hold;
    logic [1:0] exp_state;
    logic       exp_en;
    logic       exp_dir;
  } vec_t;

  vec_t vecs [13];

  ucsbece152a_counter_ctrl #(
    .WIDTH(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up_i     (btn_up),
    .btn_down_i   (btn_down),
    .btn_pause_i  (btn_pause),
    .mode_bounce_i(mode_bounce),
    .count_i      (count),
    .enable_o     (enable),
    .dir_o        (dir),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for ucsbece152a_counter: wraps naturally, same synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 3'd0;
    end else if (enable) begin
      count <= dir ? count - 3'd1 : count + 3'd1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkFsm(input string name, input logic [1:0] es, input logic een,
                          input logic edir);
    checkOutput({name, ".state"}, int'(state), int'(es));
    checkOutput({name, ".enable"}, int'(enable), int'(een));
    checkOutput({name, ".dir"}, int'(dir), int'(edir));
  endtask

  // Holds the given buttons for exactly 'hold' sampling edges, then releases and lets
  // the debouncers fully settle so the next press starts fresh.
  task automatic applyStimulus(input logic up, input logic down, input logic pause,
                               input int hold);
    @(negedge clk);
    btn_up    = up;
    btn_down  = down;
    btn_pause = pause;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_pause = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    int exp_cnt;
    logic exp_dir;

    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 3, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 7, 2'd2, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 7, 2'd3, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 7, 2'd2, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 7, 2'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 7, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 7, 2'd3, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 7, 2'd2, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 3, 2'd2, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 7, 2'd3, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 7, 2'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 7, 2'd2, 1'b1, 1'b1};

    rst         = 1'b1;
    btn_up      = 1'b0;
    btn_down    = 1'b0;
    btn_pause   = 1'b0;
    mode_bounce = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkFsm("reset", 2'd0, 1'b0, 1'b0);
    checkOutput("reset.count", int'(count), 0);

    // Press latency: event lands on the 7th sampling edge, one hold yields one event.
    btn_up = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkFsm("latency.edge6", 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkFsm("latency.edge7", 2'd1, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkFsm("latency.held", 2'd1, 1'b1, 1'b0);
    btn_up = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].up, vecs[i].down, vecs[i].pause, vecs[i].hold);
      checkFsm($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_en, vecs[i].exp_dir);
    end

    // Pause from DOWN freezes the count; resume continues downward.
    applyStimulus(1'b0, 1'b0, 1'b1, 7);
    checkFsm("pause.enter", 2'd3, 1'b0, 1'b1);
    c = int'(count);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("pause.count_hold", int'(count), c);
    applyStimulus(1'b0, 1'b0, 1'b1, 7);
    checkFsm("pause.resume", 2'd2, 1'b1, 1'b1);
    c = int'(count);
    @(posedge clk);
    @(negedge clk);
    checkOutput("resume.count_down", int'(count), (c + 7) % 8);

    pulseReset();
    checkFsm("midreset", 2'd0, 1'b0, 1'b0);
    checkOutput("midreset.count", int'(count), 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 7);
    checkFsm("idle.pause", 2'd0, 1'b0, 1'b0);

    // Button held across reset must re-debounce from scratch and fire once.
    @(negedge clk);
    btn_up = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkFsm("held.before_rst", 2'd1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkFsm("held.in_rst", 2'd0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkFsm("held.edge6", 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkFsm("held.edge7", 2'd1, 1'b1, 1'b0);
    btn_up = 1'b0;

    // Bounce: 0..7..0 then up again, with no wrap.
    @(negedge clk);
    rst         = 1'b1;
    mode_bounce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    btn_up = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    btn_up = 1'b0;
    checkFsm("bounce.start", 2'd1, 1'b1, 1'b0);
    checkOutput("bounce.count0", int'(count), 0);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_cnt = (k <= 7) ? k : ((k == 15) ? 1 : 14 - k);
      exp_dir = (k >= 7) && (k <= 13);
      checkOutput($sformatf("bounce.count[%0d]", k), int'(count), exp_cnt);
      checkOutput($sformatf("bounce.dir[%0d]", k), int'(dir), int'(exp_dir));
    end

    // Bounce off: count 1 plus seven more steps wraps through 7 to 0 still going up.
    mode_bounce = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("wrap.count", int'(count), 0);
    checkFsm("wrap", 2'd1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
